rally_controller: RTL and testbench
===================================

Name: rally_controller

Overview:
Sequences one ping-pong rally game on the 18-LED strip: serve, ball travel, return-window checks, point award, speed-up and match end. Sits between the clock divider (supplies `tick`) and the LED and score outputs. Replaces free-running LED motion with a state-machine-driven ball position. Scores feed the existing 7-segment score display path.

Parameters:
NUM_LEDS, 18, strip length; ball position range 0..NUM_LEDS-1 (0 = left end).
WIN_SCORE, 9, points needed to win; legal range 1..15.
STEP_INIT, 8, ticks per ball step at serve.
STEP_MIN, 2, fastest allowed ticks per step.
POINT_HOLD, 16, ticks spent in POINT before the next serve.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
tick  in  1  one-clk timing enable from the divider
button_L  in  1  raw left button, active-high, asynchronous to clk
button_R  in  1  raw right button, active-high, asynchronous to clk
start  in  1  raw new-match switch, active-high
leds  out  NUM_LEDS  LED strip drive
score_L  out  4  left player score
score_R  out  4  right player score
serve_side  out  1  0 = left serves, 1 = right serves
winner_L  out  1  left has won (held)
winner_R  out  1  right has won (held)

Behaviour:
- Reset (reset=0, async) values:
  - state=IDLE, pos=0, serve_side=0, scores=0, winners=0.
  - step_period=STEP_INIT, step_cnt=0, hold_cnt=0.
  - leds=one-hot bit 0.
- Inputs:
  - button_L, button_R and start each pass through a 2-flop synchroniser plus rising-edge detect.
  - Each produces a one-clk pulse: press_L, press_R, press_S.
  - Latency from raw edge to pulse: 3 clk.
  - Press pulses are evaluated on every clk, independent of `tick`.
- States: IDLE, MOVE_R, MOVE_L, POINT, GAME_OVER.
- IDLE:
  - leds=one-hot(pos); pos = 0 if serve_side=0, NUM_LEDS-1 if serve_side=1.
  - A press from the serving side starts the rally: serving L → MOVE_R; serving R → MOVE_L.
  - On entry to the rally: step_period=STEP_INIT, step_cnt=0.
  - A press from the non-serving side is ignored.
- MOVE_R:
  - On each tick, step_cnt increments. When step_cnt==step_period-1: step_cnt=0 and pos advances by one.
  - press_R with pos==NUM_LEDS-1 is a valid return:
    - next state MOVE_L, step_cnt=0;
    - step_period=max(step_period-1, STEP_MIN).
  - press_R with pos<NUM_LEDS-1 is an early swing: score_L+1, POINT.
  - Miss: a step expiring while pos==NUM_LEDS-1 (no further position) → score_L+1, POINT.
  - press_L is ignored.
- MOVE_L: mirror of MOVE_R, using end 0, press_L, decrementing pos, and score_R awarded.
- Simultaneous events:
  - press_L and press_R in the same clk: only the receiving side's press is evaluated.
  - A valid return and a step expiry in the same clk: the return wins.
- POINT:
  - leds toggle between all-ones and all-zeros on each tick, starting all-ones.
  - hold_cnt counts ticks. At POINT_HOLD:
    - if either score == WIN_SCORE → GAME_OVER, with the matching winner flag set;
    - otherwise → IDLE, with serve_side = the player who lost the point and pos set to that side's end.
- GAME_OVER:
  - leds light the winner's half: L wins → bits 0..NUM_LEDS/2-1; R wins → the upper half.
  - Button presses are ignored.
  - press_S clears scores and winners, sets serve_side=0, and goes to IDLE.
- press_S in any state other than GAME_OVER is ignored.
- Scores are 4-bit and saturate at WIN_SCORE; they never wrap.
- Asserting reset mid-rally returns every register to its reset value immediately.
- All outputs are registered; no combinational path from input to output.

Decomposition:
- Shared package (game_pkg):
  - state enum encoding (3-bit);
  - default constants NUM_LEDS=18, WIN_SCORE=9, STEP_INIT=8, STEP_MIN=2;
  - score width = 4.
- One sub-module, button_sync: 2-flop synchroniser plus rising-edge detector, async active-low reset. Instantiated three times (L, R, start).

Test Plan:
- Reset, then press_L with tick held high → MOVE_R. pos reaches 17 after 17×8=136 ticks. With no press, the next step expiry (8 ticks later) gives score_L=1 and POINT; after 16 ticks → IDLE, serve_side=1, leds=bit 17.
- Serve L, press_R while pos=17 → MOVE_L with step_period=7. Returns continue to shrink the period to 2; further returns keep it at 2.
- Serve L, press_R at pos=10 → score_L=1 immediately, POINT; press_L during MOVE_R causes no change.
- Left wins 9 points → winner_L=1, leds=0x001FF, score_L=9. Button presses are ignored. start edge → scores 0, IDLE, serve_side=0.
- press_L and press_R in the same clk while pos=17 in MOVE_R → valid return only; no score change.
- Assert reset during MOVE_L at pos=5 → all outputs at reset values within the same clk; button held across reset release produces no press pulse.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
//==============================================================================
// Package     : game_pkg
// Description : Shared types and default constants for the ping-pong rally
//               game: state encoding, strip/score geometry and a saturating
//               score increment helper.
// Revision    : 1.0 - initial release
//==============================================================================
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MOVE_R    = 3'd1,
        ST_MOVE_L    = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam int c_NUM_LEDS   = 18;
    localparam int c_WIN_SCORE  = 9;
    localparam int c_STEP_INIT  = 8;
    localparam int c_STEP_MIN   = 2;
    localparam int c_POINT_HOLD = 16;
    localparam int c_SCORE_W    = 4;

    // Scores stop at the winning value so they can never wrap.
    function automatic logic [c_SCORE_W-1:0] score_inc(
        input logic [c_SCORE_W-1:0] score,
        input logic [c_SCORE_W-1:0] limit
    );
        return (score >= limit) ? limit : score + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_sync.sv
`default_nettype none
//==============================================================================
// Module      : button_sync
// Description : Two-flop synchroniser followed by a rising-edge detector.
//               Produces a one-clk pulse three clocks after a raw rising edge.
// Ports       : clk      - system clock
//               reset    - asynchronous active-low reset
//               i_button - raw asynchronous active-high input
//               o_press  - registered one-clk press pulse
// Revision    : 1.0 - initial release
//==============================================================================
module button_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_button,
    output logic o_press
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_press;

    // The chain is preset to 1 so that a button already held while reset is
    // released looks like "still pressed" and produces no edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_prev  <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_meta  <= i_button;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_press <= r_sync & ~r_prev;
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/rally_controller.sv
`default_nettype none
//==============================================================================
// Module      : rally_controller
// Description : Sequences one ping-pong rally game on the LED strip: serve,
//               ball travel, return checks, point award, speed-up, match end.
// Ports       : clk, reset (async active-low), tick (timing enable),
//               button_L/button_R/start (raw inputs),
//               leds, score_L, score_R, serve_side, winner_L, winner_R
//               (all registered outputs).
// Revision    : 1.0 - initial release
//==============================================================================
module rally_controller
    import game_pkg::*;
#(
    parameter int NUM_LEDS   = c_NUM_LEDS,
    parameter int WIN_SCORE  = c_WIN_SCORE,
    parameter int STEP_INIT  = c_STEP_INIT,
    parameter int STEP_MIN   = c_STEP_MIN,
    parameter int POINT_HOLD = c_POINT_HOLD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 button_L,
    input  logic                 button_R,
    input  logic                 start,
    output logic [NUM_LEDS-1:0]  leds,
    output logic [c_SCORE_W-1:0] score_L,
    output logic [c_SCORE_W-1:0] score_R,
    output logic                 serve_side,
    output logic                 winner_L,
    output logic                 winner_R
);

    localparam int c_POS_W  = $clog2(NUM_LEDS);
    localparam int c_STEP_W = $clog2(STEP_INIT + 1);
    localparam int c_HOLD_W = $clog2(POINT_HOLD + 1);

    localparam logic [c_POS_W-1:0]   c_POS_LAST  = c_POS_W'(NUM_LEDS - 1);
    localparam logic [c_STEP_W-1:0]  c_STEP_INIT_V = c_STEP_W'(STEP_INIT);
    localparam logic [c_STEP_W-1:0]  c_STEP_MIN_V  = c_STEP_W'(STEP_MIN);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST = c_HOLD_W'(POINT_HOLD - 1);
    localparam logic [c_SCORE_W-1:0] c_WIN       = c_SCORE_W'(WIN_SCORE);
    localparam logic [NUM_LEDS-1:0]  c_LED0      = {{(NUM_LEDS-1){1'b0}}, 1'b1};
    localparam logic [NUM_LEDS-1:0]  c_LEFT_HALF = {NUM_LEDS{1'b1}} >> (NUM_LEDS - NUM_LEDS/2);
    localparam logic [NUM_LEDS-1:0]  c_RIGHT_HALF = ~c_LEFT_HALF;

    logic w_press_L;
    logic w_press_R;
    logic w_press_S;

    button_sync u_sync_L (.clk(clk), .reset(reset), .i_button(button_L), .o_press(w_press_L));
    button_sync u_sync_R (.clk(clk), .reset(reset), .i_button(button_R), .o_press(w_press_R));
    button_sync u_sync_S (.clk(clk), .reset(reset), .i_button(start),    .o_press(w_press_S));

    state_t                r_state,       w_state;
    logic [c_POS_W-1:0]    r_pos,         w_pos;
    logic                  r_serve_side,  w_serve_side;
    logic [c_SCORE_W-1:0]  r_score_L,     w_score_L;
    logic [c_SCORE_W-1:0]  r_score_R,     w_score_R;
    logic                  r_winner_L,    w_winner_L;
    logic                  r_winner_R,    w_winner_R;
    logic [c_STEP_W-1:0]   r_step_period, w_step_period;
    logic [c_STEP_W-1:0]   r_step_cnt,    w_step_cnt;
    logic [c_HOLD_W-1:0]   r_hold_cnt,    w_hold_cnt;
    logic                  r_point_to_L,  w_point_to_L;  // who won the last point
    logic [NUM_LEDS-1:0]   r_leds,        w_leds;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_pos         <= '0;
            r_serve_side  <= 1'b0;
            r_score_L     <= '0;
            r_score_R     <= '0;
            r_winner_L    <= 1'b0;
            r_winner_R    <= 1'b0;
            r_step_period <= c_STEP_INIT_V;
            r_step_cnt    <= '0;
            r_hold_cnt    <= '0;
            r_point_to_L  <= 1'b0;
            r_leds        <= c_LED0;
        end else begin
            r_state       <= w_state;
            r_pos         <= w_pos;
            r_serve_side  <= w_serve_side;
            r_score_L     <= w_score_L;
            r_score_R     <= w_score_R;
            r_winner_L    <= w_winner_L;
            r_winner_R    <= w_winner_R;
            r_step_period <= w_step_period;
            r_step_cnt    <= w_step_cnt;
            r_hold_cnt    <= w_hold_cnt;
            r_point_to_L  <= w_point_to_L;
            r_leds        <= w_leds;
        end
    end

    // Next-state logic. Within a rally the receiver's press is checked before
    // the step timer, so a valid return beats a simultaneous step expiry.
    always_comb begin
        w_state       = r_state;
        w_pos         = r_pos;
        w_serve_side  = r_serve_side;
        w_score_L     = r_score_L;
        w_score_R     = r_score_R;
        w_winner_L    = r_winner_L;
        w_winner_R    = r_winner_R;
        w_step_period = r_step_period;
        w_step_cnt    = r_step_cnt;
        w_hold_cnt    = r_hold_cnt;
        w_point_to_L  = r_point_to_L;

        case (r_state)
            ST_IDLE: begin
                if ((!r_serve_side && w_press_L) || (r_serve_side && w_press_R)) begin
                    w_state       = r_serve_side ? ST_MOVE_L : ST_MOVE_R;
                    w_step_period = c_STEP_INIT_V;
                    w_step_cnt    = '0;
                end
            end
            ST_MOVE_R: begin
                if (w_press_R) begin
                    if (r_pos == c_POS_LAST) begin
                        w_state       = ST_MOVE_L;
                        w_step_cnt    = '0;
                        w_step_period = (r_step_period > c_STEP_MIN_V) ?
                                        r_step_period - 1'b1 : c_STEP_MIN_V;
                    end else begin
                        w_state      = ST_POINT;
                        w_score_L    = score_inc(r_score_L, c_WIN);
                        w_point_to_L = 1'b1;
                        w_hold_cnt   = '0;
                    end
                end else if (tick) begin
                    if (r_step_cnt == r_step_period - 1'b1) begin
                        w_step_cnt = '0;
                        if (r_pos == c_POS_LAST) begin
                            w_state      = ST_POINT;
                            w_score_L    = score_inc(r_score_L, c_WIN);
                            w_point_to_L = 1'b1;
                            w_hold_cnt   = '0;
                        end else begin
                            w_pos = r_pos + 1'b1;
                        end
                    end else begin
                        w_step_cnt = r_step_cnt + 1'b1;
                    end
                end
            end
            ST_MOVE_L: begin
                if (w_press_L) begin
                    if (r_pos == '0) begin
                        w_state       = ST_MOVE_R;
                        w_step_cnt    = '0;
                        w_step_period = (r_step_period > c_STEP_MIN_V) ?
                                        r_step_period - 1'b1 : c_STEP_MIN_V;
                    end else begin
                        w_state      = ST_POINT;
                        w_score_R    = score_inc(r_score_R, c_WIN);
                        w_point_to_L = 1'b0;
                        w_hold_cnt   = '0;
                    end
                end else if (tick) begin
                    if (r_step_cnt == r_step_period - 1'b1) begin
                        w_step_cnt = '0;
                        if (r_pos == '0) begin
                            w_state      = ST_POINT;
                            w_score_R    = score_inc(r_score_R, c_WIN);
                            w_point_to_L = 1'b0;
                            w_hold_cnt   = '0;
                        end else begin
                            w_pos = r_pos - 1'b1;
                        end
                    end else begin
                        w_step_cnt = r_step_cnt + 1'b1;
                    end
                end
            end
            ST_POINT: begin
                if (tick) begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        w_hold_cnt = '0;
                        if (r_score_L == c_WIN) begin
                            w_state    = ST_GAME_OVER;
                            w_winner_L = 1'b1;
                        end else if (r_score_R == c_WIN) begin
                            w_state    = ST_GAME_OVER;
                            w_winner_R = 1'b1;
                        end else begin
                            // The player who lost the point serves next.
                            w_state      = ST_IDLE;
                            w_serve_side = r_point_to_L;
                            w_pos        = r_point_to_L ? c_POS_LAST : '0;
                        end
                    end else begin
                        w_hold_cnt = r_hold_cnt + 1'b1;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (w_press_S) begin
                    w_state      = ST_IDLE;
                    w_score_L    = '0;
                    w_score_R    = '0;
                    w_winner_L   = 1'b0;
                    w_winner_R   = 1'b0;
                    w_serve_side = 1'b0;
                    w_pos        = '0;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_pos   = '0;
            end
        endcase
    end

    // LED pattern derived from the next state so it is registered alongside it.
    always_comb begin
        w_leds = r_leds;
        case (w_state)
            ST_IDLE, ST_MOVE_R, ST_MOVE_L: w_leds = c_LED0 << w_pos;
            ST_POINT: begin
                if (r_state != ST_POINT) begin
                    w_leds = '1;
                end else if (tick) begin
                    w_leds = ~r_leds;
                end
            end
            ST_GAME_OVER: w_leds = w_winner_L ? c_LEFT_HALF : c_RIGHT_HALF;
            default:      w_leds = c_LED0;
        endcase
    end

    assign leds       = r_leds;
    assign score_L    = r_score_L;
    assign score_R    = r_score_R;
    assign serve_side = r_serve_side;
    assign winner_L   = r_winner_L;
    assign winner_R   = r_winner_R;

endmodule
`default_nettype wire

// File: tb/tb_rally_controller.sv
`default_nettype none
//==============================================================================
// Module      : tb_rally_controller
// Description : Self-checking bench for rally_controller. Expected output
//               snapshots are queued as stimulus is applied and compared once
//               the DUT has responded.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_rally_controller;

    localparam int N = 18;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         tick = 1'b0;
    logic         button_L = 1'b0;
    logic         button_R = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] leds;
    logic [3:0]   score_L;
    logic [3:0]   score_R;
    logic         serve_side;
    logic         winner_L;
    logic         winner_R;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rally_controller dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .button_L  (button_L),
        .button_R  (button_R),
        .start     (start),
        .leds      (leds),
        .score_L   (score_L),
        .score_R   (score_R),
        .serve_side(serve_side),
        .winner_L  (winner_L),
        .winner_R  (winner_R)
    );

    typedef struct {
        string        name;
        logic [N-1:0] leds;
        logic [3:0]   sl;
        logic [3:0]   sr;
        logic         serve;
        logic         wl;
        logic         wr;
    } exp_t;

    typedef struct {
        bit side_r;    // 1: right player returns, 0: left player returns
        int period;    // expected ticks per step after this return
        int end_pos;
        int next_pos;
        int far_pos;
    } ret_vec_t;

    exp_t     sb_q[$];
    ret_vec_t ret_tbl[8];

    function automatic logic [N-1:0] onehot(input int p);
        logic [N-1:0] v;
        v = {{(N-1){1'b0}}, 1'b1};
        return v << p;
    endfunction

    task automatic sb_push(input string name, input logic [N-1:0] l, input int sl,
                           input int sr, input logic serve, input logic wl, input logic wr);
        exp_t e;
        e.name = name; e.leds = l; e.sl = 4'(sl); e.sr = 4'(sr);
        e.serve = serve; e.wl = wl; e.wr = wr;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = sb_q.pop_front();
        if (leds !== e.leds || score_L !== e.sl || score_R !== e.sr ||
            serve_side !== e.serve || winner_L !== e.wl || winner_R !== e.wr) begin
            errors++;
            $display("FAIL %s: got leds=%h sL=%0d sR=%0d serve=%b wL=%b wR=%b, want leds=%h sL=%0d sR=%0d serve=%b wL=%b wR=%b",
                     e.name, leds, score_L, score_R, serve_side, winner_L, winner_R,
                     e.leds, e.sl, e.sr, e.serve, e.wl, e.wr);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_ticks(input int n);
        if (n > 0) begin
            tick = 1'b1;
            clocks(n);
            tick = 1'b0;
        end
    endtask

    // Raw press held long enough for the 3-clk synchroniser, then released.
    task automatic press(input logic l, input logic r, input logic s);
        button_L = l; button_R = r; start = s;
        clocks(5);
        button_L = 1'b0; button_R = 1'b0; start = 1'b0;
        clocks(3);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clocks(3);
        reset = 1'b1;
        clocks(4);
    endtask

    initial begin
        ret_tbl[0] = '{1'b1, 7, 17, 16, 0};
        ret_tbl[1] = '{1'b0, 6, 0, 1, 17};
        ret_tbl[2] = '{1'b1, 5, 17, 16, 0};
        ret_tbl[3] = '{1'b0, 4, 0, 1, 17};
        ret_tbl[4] = '{1'b1, 3, 17, 16, 0};
        ret_tbl[5] = '{1'b0, 2, 0, 1, 17};
        ret_tbl[6] = '{1'b1, 2, 17, 16, 0};
        ret_tbl[7] = '{1'b0, 2, 0, 1, 17};

        @(negedge clk);
        do_reset();

        // Serve left, travel, miss, point hold, hand serve to the right.
        sb_push("reset_state", onehot(0), 0, 0, 1'b0, 1'b0, 1'b0);
        sb_check();
        press(1'b1, 1'b0, 1'b0);
        sb_push("reach_17", onehot(17), 0, 0, 1'b0, 1'b0, 1'b0);
        run_ticks(136); sb_check();
        sb_push("hold_17", onehot(17), 0, 0, 1'b0, 1'b0, 1'b0);
        run_ticks(7); sb_check();
        sb_push("miss_point", '1, 1, 0, 1'b0, 1'b0, 1'b0);
        run_ticks(1); sb_check();
        sb_push("point_blink", '0, 1, 0, 1'b0, 1'b0, 1'b0);
        run_ticks(15); sb_check();
        sb_push("point_to_idle", onehot(17), 1, 0, 1'b1, 1'b0, 1'b0);
        run_ticks(1); sb_check();

        // Returns shrink the step period down to the minimum.
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        sb_push("rally_reach_17", onehot(17), 0, 0, 1'b0, 1'b0, 1'b0);
        run_ticks(136); sb_check();
        for (int i = 0; i < 8; i++) begin
            sb_push($sformatf("ret%0d_at_end", i), onehot(ret_tbl[i].end_pos), 0, 0, 1'b0, 1'b0, 1'b0);
            press(!ret_tbl[i].side_r, ret_tbl[i].side_r, 1'b0);
            run_ticks(ret_tbl[i].period - 1); sb_check();
            sb_push($sformatf("ret%0d_step", i), onehot(ret_tbl[i].next_pos), 0, 0, 1'b0, 1'b0, 1'b0);
            run_ticks(1); sb_check();
            sb_push($sformatf("ret%0d_far", i), onehot(ret_tbl[i].far_pos), 0, 0, 1'b0, 1'b0, 1'b0);
            run_ticks(16 * ret_tbl[i].period); sb_check();
        end

        // Ignored press_L in MOVE_R, then an early swing by the right.
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        sb_push("mid_pos10", onehot(10), 0, 0, 1'b0, 1'b0, 1'b0);
        run_ticks(80); sb_check();
        sb_push("press_L_ignored", onehot(10), 0, 0, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0); sb_check();
        sb_push("still_moving", onehot(11), 0, 0, 1'b0, 1'b0, 1'b0);
        run_ticks(8); sb_check();
        sb_push("early_swing", '1, 1, 0, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0); sb_check();

        // Left wins the match.
        sb_push("serve_to_R", onehot(17), 1, 0, 1'b1, 1'b0, 1'b0);
        run_ticks(16); sb_check();
        for (int pts = 2; pts <= 9; pts++) begin
            press(1'b0, 1'b1, 1'b0);
            run_ticks(136);
            press(1'b1, 1'b0, 1'b0);
            sb_push($sformatf("early_pt%0d", pts), '1, pts, 0, 1'b1, 1'b0, 1'b0);
            press(1'b0, 1'b1, 1'b0); sb_check();
            if (pts == 9)
                sb_push("game_over", 18'h001FF, 9, 0, 1'b1, 1'b1, 1'b0);
            else
                sb_push($sformatf("idle_pt%0d", pts), onehot(17), pts, 0, 1'b1, 1'b0, 1'b0);
            run_ticks(16); sb_check();
        end
        sb_push("game_over_buttons_ignored", 18'h001FF, 9, 0, 1'b1, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        sb_check();
        sb_push("new_match", onehot(0), 0, 0, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1); sb_check();

        // Both buttons at the right end: only the return counts.
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        run_ticks(136);
        sb_push("both_press_return", onehot(17), 0, 0, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0); sb_check();
        sb_push("both_press_move_L", onehot(16), 0, 0, 1'b0, 1'b0, 1'b0);
        run_ticks(7); sb_check();

        // Asynchronous reset mid-rally with a button held across release.
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        run_ticks(16);
        press(1'b0, 1'b1, 1'b0);
        sb_push("move_L_pos5", onehot(5), 1, 0, 1'b1, 1'b0, 1'b0);
        run_ticks(96); sb_check();
        #2;
        button_L = 1'b1;
        reset = 1'b0;
        #1;
        sb_push("async_reset", onehot(0), 0, 0, 1'b0, 1'b0, 1'b0);
        sb_check();
        clocks(2);
        reset = 1'b1;
        sb_push("held_button_no_press", onehot(0), 0, 0, 1'b0, 1'b0, 1'b0);
        run_ticks(20); sb_check();
        button_L = 1'b0;
        clocks(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
